// File: rtl/res_wr_arbiter.sv
// -----------------------------------------------------------------------------
// res_wr_arbiter
//
// Sits between the ALU functional units and the result FIFO (FIFO out). Two
// sources present finished, tagged result words: the multiplier (source 0) and
// the add/sub/logic unit (source 1). A round-robin arbiter grants one of them,
// writes its word into FIFO out, and sends the winner a one-cycle "written"
// pulse so it can leave its save/hold state.
//
// Each grant takes three cycles: IDLE (arbitrate and capture), WRITE (strobe
// the FIFO and pulse the winner), RELEASE (give the winner a cycle to drop
// its valid so it is not granted twice).
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   mul_valid_res   multiplier result ready (level, held until mul_written)
//   mul_result      multiplier result word {id, flag, payload}
//   alu_valid_res   add/sub/logic result ready (level, held until alu_written)
//   alu_result      add/sub/logic result word {id, flag, payload}
//   ready_f_res     FIFO out not full
//   mul_written     one-cycle pulse, multiplier word committed
//   alu_written     one-cycle pulse, alu word committed
//   fifo_wr_en      FIFO out write strobe
//   fifo_wr_data    word written to FIFO out (meaningful only with fifo_wr_en)
//   last_grant      source of the most recent write (0 = mul, 1 = alu)
//   mul_wr_cnt      wrapping count of multiplier words written
//   alu_wr_cnt      wrapping count of alu words written
// -----------------------------------------------------------------------------
module res_wr_arbiter #(
   parameter int   DATA_SIZE = 16,
   parameter int   ID_SIZE   = 8,
   parameter int   CNT_SIZE  = 8,
   localparam int  RES_W     = DATA_SIZE + 1 + ID_SIZE
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                mul_valid_res,
   input  logic [RES_W-1:0]    mul_result,
   input  logic                alu_valid_res,
   input  logic [RES_W-1:0]    alu_result,
   input  logic                ready_f_res,
   output logic                mul_written,
   output logic                alu_written,
   output logic                fifo_wr_en,
   output logic [RES_W-1:0]    fifo_wr_data,
   output logic                last_grant,
   output logic [CNT_SIZE-1:0] mul_wr_cnt,
   output logic [CNT_SIZE-1:0] alu_wr_cnt
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WRITE   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t              state_q,     state_d;
   logic                grantSel_q,  grantSel_d;
   logic                lastGrant_q, lastGrant_d;
   logic [RES_W-1:0]    wrData_q,    wrData_d;
   logic [CNT_SIZE-1:0] mulCnt_q,    mulCnt_d;
   logic [CNT_SIZE-1:0] aluCnt_q,    aluCnt_d;

   // Round-robin choice made in IDLE. With a single requester it simply wins;
   // with both requesting, the one that did not win last time goes next.
   // last_grant resets to 1 so the multiplier takes the very first tie.
   logic winner;
   always_comb begin
      winner = alu_valid_res;
      if (mul_valid_res && alu_valid_res) begin
         winner = ~lastGrant_q;
      end
   end

   // Next-state and register-update logic. Everything holds by default; the
   // FIFO-ready check only happens in IDLE because this block is the only
   // writer, so the FIFO cannot fill between the grant and the write. The
   // history bit and the per-source counter are updated as WRITE completes.
   always_comb begin
      state_d     = state_q;
      grantSel_d  = grantSel_q;
      lastGrant_d = lastGrant_q;
      wrData_d    = wrData_q;
      mulCnt_d    = mulCnt_q;
      aluCnt_d    = aluCnt_q;
      case (state_q)
         IDLE: begin
            if ((mul_valid_res || alu_valid_res) && ready_f_res) begin
               grantSel_d = winner;
               wrData_d   = winner ? alu_result : mul_result;
               state_d    = WRITE;
            end
         end
         WRITE: begin
            lastGrant_d = grantSel_q;
            if (grantSel_q) begin
               aluCnt_d = aluCnt_q + CNT_SIZE'(1);
            end else begin
               mulCnt_d = mulCnt_q + CNT_SIZE'(1);
            end
            state_d = RELEASE;
         end
         RELEASE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers. Reset aborts any transaction in flight, so
   // no write or written pulse can appear in the cycle after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         grantSel_q  <= 1'b0;
         lastGrant_q <= 1'b1;
         wrData_q    <= '0;
         mulCnt_q    <= '0;
         aluCnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         grantSel_q  <= grantSel_d;
         lastGrant_q <= lastGrant_d;
         wrData_q    <= wrData_d;
         mulCnt_q    <= mulCnt_d;
         aluCnt_q    <= aluCnt_d;
      end
   end

   // Outputs decode only from registers: the write strobe is the WRITE state,
   // and exactly one written pulse accompanies it, selected by the grant.
   always_comb begin
      fifo_wr_en   = (state_q == WRITE);
      mul_written  = (state_q == WRITE) && !grantSel_q;
      alu_written  = (state_q == WRITE) &&  grantSel_q;
      fifo_wr_data = wrData_q;
      last_grant   = lastGrant_q;
      mul_wr_cnt   = mulCnt_q;
      alu_wr_cnt   = aluCnt_q;
   end

endmodule

// File: tb/tb_res_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_res_wr_arbiter
//
// Self-checking bench for res_wr_arbiter. A directed table covers reset, a
// lone multiplier write and four alternating contended grants; hand-written
// sequences cover a full FIFO, reset during WRITE, counter wrap and a valid
// arriving during WRITE; a randomized phase drives both sources against a
// behavioural reference model.
// -----------------------------------------------------------------------------
module tb_res_wr_arbiter;

   localparam int DS = 16;
   localparam int IS = 8;
   localparam int CW = 8;
   localparam int RW = DS + 1 + IS;

   logic          clk;
   logic          rst;
   logic          mulV;
   logic [RW-1:0] mulR;
   logic          aluV;
   logic [RW-1:0] aluR;
   logic          ready;
   logic          mul_written;
   logic          alu_written;
   logic          fifo_wr_en;
   logic [RW-1:0] fifo_wr_data;
   logic          last_grant;
   logic [CW-1:0] mul_wr_cnt;
   logic [CW-1:0] alu_wr_cnt;

   int checks = 0;
   int errors = 0;

   res_wr_arbiter #(.DATA_SIZE(DS), .ID_SIZE(IS), .CNT_SIZE(CW)) dut (
      .clk           (clk),
      .rst           (rst),
      .mul_valid_res (mulV),
      .mul_result    (mulR),
      .alu_valid_res (aluV),
      .alu_result    (aluR),
      .ready_f_res   (ready),
      .mul_written   (mul_written),
      .alu_written   (alu_written),
      .fifo_wr_en    (fifo_wr_en),
      .fifo_wr_data  (fifo_wr_data),
      .last_grant    (last_grant),
      .mul_wr_cnt    (mul_wr_cnt),
      .alu_wr_cnt    (alu_wr_cnt)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something stalls the run.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model. After each grant the arbiter is blind for two samples
   // (the write cycle and the cooling cycle); the history bit and the counter
   // of the winner change once its write cycle is over.
   int            mBusy;
   bit            mCommit;
   bit            mPendSrc;
   bit            mLast;
   logic [CW-1:0] mMulCnt;
   logic [CW-1:0] mAluCnt;
   logic [RW-1:0] mData;
   bit            mWrEn;
   bit            mMulW;
   bit            mAluW;

   task automatic modelStep();
      bit src;
      if (rst) begin
         mBusy = 0; mCommit = 0; mPendSrc = 0; mLast = 1;
         mMulCnt = '0; mAluCnt = '0; mData = '0;
         mWrEn = 0; mMulW = 0; mAluW = 0;
      end else begin
         mWrEn = 0; mMulW = 0; mAluW = 0;
         if (mCommit) begin
            mLast = mPendSrc;
            if (mPendSrc) mAluCnt = mAluCnt + 8'd1;
            else          mMulCnt = mMulCnt + 8'd1;
            mCommit = 0;
         end
         if (mBusy > 0) begin
            mBusy--;
         end else if ((mulV || aluV) && ready) begin
            src      = (mulV && aluV) ? !mLast : aluV;
            mData    = src ? aluR : mulR;
            mWrEn    = 1;
            mMulW    = !src;
            mAluW    = src;
            mPendSrc = src;
            mCommit  = 1;
            mBusy    = 2;
         end
      end
   endtask

   // One clock: advance the model on the inputs as they stand, then sample
   // the DUT 1 unit after the rising edge.
   task automatic tick();
      modelStep();
      @(posedge clk);
      #1;
   endtask

   task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      checkField({tag, ".wr_en"},   32'(fifo_wr_en),   32'(mWrEn));
      checkField({tag, ".mul_w"},   32'(mul_written),  32'(mMulW));
      checkField({tag, ".alu_w"},   32'(alu_written),  32'(mAluW));
      checkField({tag, ".data"},    32'(fifo_wr_data), 32'(mData));
      checkField({tag, ".last"},    32'(last_grant),   32'(mLast));
      checkField({tag, ".mul_cnt"}, 32'(mul_wr_cnt),   32'(mMulCnt));
      checkField({tag, ".alu_cnt"}, 32'(alu_wr_cnt),   32'(mAluCnt));
   endtask

   // Directed vectors: inputs before an edge, outputs expected after it.
   typedef struct {
      logic          rst;
      logic          mv;
      logic [RW-1:0] mr;
      logic          av;
      logic [RW-1:0] ar;
      logic          rdy;
      logic          wr;
      logic          mw;
      logic          aw;
      logic [RW-1:0] d;
      logic          lg;
      logic [CW-1:0] mc;
      logic [CW-1:0] ac;
   } vec_t;

   vec_t vecs[16];

   function automatic vec_t mkVec(logic r, logic mv, logic [RW-1:0] mr, logic av,
                                  logic [RW-1:0] ar, logic rdy, logic wr, logic mw,
                                  logic aw, logic [RW-1:0] d, logic lg,
                                  logic [CW-1:0] mc, logic [CW-1:0] ac);
      vec_t v;
      v.rst = r; v.mv = mv; v.mr = mr; v.av = av; v.ar = ar; v.rdy = rdy;
      v.wr = wr; v.mw = mw; v.aw = aw; v.d = d; v.lg = lg; v.mc = mc; v.ac = ac;
      return v;
   endfunction

   task automatic applyStimulus(input vec_t v);
      rst   = v.rst;
      mulV  = v.mv;
      mulR  = v.mr;
      aluV  = v.av;
      aluR  = v.ar;
      ready = v.rdy;
   endtask

   // Granted sources drop their valid right after their written pulse.
   task automatic dropWritten();
      if (mMulW) mulV = 1'b0;
      if (mAluW) aluV = 1'b0;
   endtask

   task automatic doReset();
      rst = 1'b1;
      tick();
      checkOutput("reset");
      rst = 1'b0;
   endtask

   initial begin
      logic [RW-1:0] sw;
      logic [RW-1:0] mw;
      logic [RW-1:0] aw;
      int            gap;
      int            mulRepeat;
      bit            seen;
      int            writes;

      sw = {8'h3C, 1'b0, 16'h00C8};
      mw = {8'hA5, 1'b0, 16'hAAAA};
      aw = {8'h5A, 1'b1, 16'h5555};

      rst = 1'b1; mulV = 1'b0; aluV = 1'b0; mulR = '0; aluR = '0; ready = 1'b1;

      vecs[0]  = mkVec(1, 0, '0, 0, '0, 1,   0, 0, 0, '0, 1, 8'd0, 8'd0);
      vecs[1]  = mkVec(0, 1, sw, 0, '0, 1,   1, 1, 0, sw, 1, 8'd0, 8'd0);
      vecs[2]  = mkVec(0, 0, sw, 0, '0, 1,   0, 0, 0, sw, 0, 8'd1, 8'd0);
      vecs[3]  = mkVec(0, 0, sw, 0, '0, 1,   0, 0, 0, sw, 0, 8'd1, 8'd0);
      vecs[4]  = mkVec(1, 0, '0, 0, '0, 1,   0, 0, 0, '0, 1, 8'd0, 8'd0);
      vecs[5]  = mkVec(0, 1, mw, 1, aw, 1,   1, 1, 0, mw, 1, 8'd0, 8'd0);
      vecs[6]  = mkVec(0, 1, mw, 1, aw, 1,   0, 0, 0, mw, 0, 8'd1, 8'd0);
      vecs[7]  = mkVec(0, 1, mw, 1, aw, 1,   0, 0, 0, mw, 0, 8'd1, 8'd0);
      vecs[8]  = mkVec(0, 1, mw, 1, aw, 1,   1, 0, 1, aw, 0, 8'd1, 8'd0);
      vecs[9]  = mkVec(0, 1, mw, 1, aw, 1,   0, 0, 0, aw, 1, 8'd1, 8'd1);
      vecs[10] = mkVec(0, 1, mw, 1, aw, 1,   0, 0, 0, aw, 1, 8'd1, 8'd1);
      vecs[11] = mkVec(0, 1, mw, 1, aw, 1,   1, 1, 0, mw, 1, 8'd1, 8'd1);
      vecs[12] = mkVec(0, 1, mw, 1, aw, 1,   0, 0, 0, mw, 0, 8'd2, 8'd1);
      vecs[13] = mkVec(0, 1, mw, 1, aw, 1,   0, 0, 0, mw, 0, 8'd2, 8'd1);
      vecs[14] = mkVec(0, 1, mw, 1, aw, 1,   1, 0, 1, aw, 0, 8'd2, 8'd1);
      vecs[15] = mkVec(0, 1, mw, 1, aw, 1,   0, 0, 0, aw, 1, 8'd2, 8'd2);

      // Directed table: reset, single multiplier write, alternating contention.
      for (int i = 0; i < 16; i++) begin
         applyStimulus(vecs[i]);
         tick();
         checkField($sformatf("vec%0d.wr_en", i),   32'(fifo_wr_en),   32'(vecs[i].wr));
         checkField($sformatf("vec%0d.mul_w", i),   32'(mul_written),  32'(vecs[i].mw));
         checkField($sformatf("vec%0d.alu_w", i),   32'(alu_written),  32'(vecs[i].aw));
         checkField($sformatf("vec%0d.data", i),    32'(fifo_wr_data), 32'(vecs[i].d));
         checkField($sformatf("vec%0d.last", i),    32'(last_grant),   32'(vecs[i].lg));
         checkField($sformatf("vec%0d.mul_cnt", i), 32'(mul_wr_cnt),   32'(vecs[i].mc));
         checkField($sformatf("vec%0d.alu_cnt", i), 32'(alu_wr_cnt),   32'(vecs[i].ac));
      end
      mulV = 1'b0; aluV = 1'b0;

      // FIFO full: both sources wait, then the multiplier goes first.
      doReset();
      mulV = 1'b1; mulR = mw; aluV = 1'b1; aluR = aw; ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         checkOutput("full.hold");
      end
      ready = 1'b1;
      tick();
      checkOutput("full.first");
      checkField("full.firstIsMul", 32'(mul_written), 32'd1);
      checkField("full.firstData", 32'(fifo_wr_data), 32'(mw));
      for (int i = 0; i < 8; i++) begin
         dropWritten();
         tick();
         checkOutput("full.drain");
      end

      // Reset during WRITE: everything returns to reset values, no rewrite.
      doReset();
      mulV = 1'b1; mulR = sw;
      tick();
      checkOutput("midrst.write");
      rst = 1'b1; mulV = 1'b0;
      tick();
      checkOutput("midrst.reset");
      checkField("midrst.last", 32'(last_grant), 32'd1);
      checkField("midrst.cnt", 32'(mul_wr_cnt), 32'd0);
      rst = 1'b0;
      writes = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("midrst.after");
         writes += int'(fifo_wr_en);
      end
      checkField("midrst.noDup", 32'(writes), 32'd0);

      // Counter wrap: 256 lone multiplier writes bring the count back to 0.
      doReset();
      for (int n = 0; n < 256; n++) begin
         mulV = 1'b1;
         mulR = RW'($urandom);
         seen = 0;
         for (int k = 0; k < 5 && !seen; k++) begin
            tick();
            checkOutput("wrap");
            seen = mMulW;
         end
         if (!seen) begin
            errors++;
            $display("[TB] FAIL wrap.timeout actual=noWrite required=write");
         end
         mulV = 1'b0;
         tick();
         tick();
      end
      checkField("wrap.mulCnt", 32'(mul_wr_cnt), 32'd0);
      checkField("wrap.aluCnt", 32'(alu_wr_cnt), 32'd0);

      // Late valid: alu rises during the mul write and is written 3 cycles on.
      doReset();
      mulV = 1'b1; mulR = mw;
      tick();
      checkOutput("late.mul");
      mulV = 1'b0; aluV = 1'b1; aluR = aw;
      gap = 0; mulRepeat = 0; seen = 0;
      for (int k = 0; k < 6 && !seen; k++) begin
         tick();
         checkOutput("late.wait");
         gap++;
         mulRepeat += int'(mul_written);
         seen = alu_written;
      end
      checkField("late.gap", 32'(gap), 32'd3);
      checkField("late.noRepeat", 32'(mulRepeat), 32'd0);
      checkField("late.data", 32'(fifo_wr_data), 32'(aw));
      aluV = 1'b0;
      tick();
      checkOutput("late.release");

      // Randomized traffic against the reference model.
      doReset();
      for (int i = 0; i < 2000; i++) begin
         dropWritten();
         if (!mulV && ($urandom_range(3) == 0)) begin
            mulV = 1'b1; mulR = RW'($urandom);
         end
         if (!aluV && ($urandom_range(3) == 0)) begin
            aluV = 1'b1; aluR = RW'($urandom);
         end
         ready = ($urandom_range(3) != 0);
         rst   = ($urandom_range(199) == 0);
         tick();
         checkOutput("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
